// File: rtl/dip_psum_collector.sv
// Collects psum rows from the last DiP array row, sums NUM_TILES K-passes into an
// N x N buffer with saturation, then drains the result row by row over valid/ready.
module dip_psum_collector #(
    parameter int N         = 4,
    parameter int PSUM_W    = 24,
    parameter int ACC_W     = 32,
    parameter int NUM_TILES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [N*PSUM_W-1:0]   in_row,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N*ACC_W-1:0]    out_row,
    output logic                  out_last,
    output logic                  overflow,
    output logic                  busy
);

    localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
    localparam int TILE_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {ACCUM, DRAIN} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         row_cnt_q, row_cnt_d;
    logic [CNT_W-1:0]         drain_cnt_q, drain_cnt_d;
    logic [TILE_W-1:0]        tile_cnt_q, tile_cnt_d;
    logic                     sat_q, sat_d;
    logic signed [ACC_W-1:0]  acc_q [N][N];
    logic signed [ACC_W-1:0]  acc_d [N][N];
    logic signed [ACC_W-1:0]  lane_ext [N];
    logic signed [ACC_W:0]    sum_w [N];

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [PSUM_W-1:0] v);
        return ACC_W'(v);
    endfunction

    function automatic logic signed [ACC_W:0] add_wide(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
        return {a[ACC_W-1], a} + {b[ACC_W-1], b};
    endfunction

    // The extra sum bit disagreeing with the ACC_W sign bit means the sum left range.
    function automatic logic clamps(input logic signed [ACC_W:0] s);
        return s[ACC_W] != s[ACC_W-1];
    endfunction

    function automatic logic signed [ACC_W-1:0] sat(input logic signed [ACC_W:0] s);
        if (!clamps(s)) begin
            return s[ACC_W-1:0];
        end else if (s[ACC_W]) begin
            return ACC_MIN;
        end else begin
            return ACC_MAX;
        end
    endfunction

    always_comb begin
        for (int k = 0; k < N; k++) begin
            lane_ext[k] = sext(in_row[k*PSUM_W +: PSUM_W]);
            sum_w[k]    = add_wide(acc_q[row_cnt_q][k], lane_ext[k]);
        end
    end

    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        drain_cnt_d = drain_cnt_q;
        tile_cnt_d  = tile_cnt_q;
        sat_d       = sat_q;
        acc_d       = acc_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        out_row     = '0;

        case (state_q)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    for (int k = 0; k < N; k++) begin
                        if (tile_cnt_q == '0) begin
                            acc_d[row_cnt_q][k] = lane_ext[k];
                        end else begin
                            acc_d[row_cnt_q][k] = sat(sum_w[k]);
                            if (clamps(sum_w[k])) begin
                                sat_d = 1'b1;
                            end
                        end
                    end
                    if (row_cnt_q == CNT_W'(N-1)) begin
                        row_cnt_d = '0;
                        if (tile_cnt_q == TILE_W'(NUM_TILES-1)) begin
                            tile_cnt_d  = '0;
                            drain_cnt_d = '0;
                            state_d     = DRAIN;
                        end else begin
                            tile_cnt_d = tile_cnt_q + 1'b1;
                        end
                    end else begin
                        row_cnt_d = row_cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_last  = (drain_cnt_q == CNT_W'(N-1));
                for (int k = 0; k < N; k++) begin
                    out_row[k*ACC_W +: ACC_W] = acc_q[drain_cnt_q][k];
                end
                if (out_ready) begin
                    if (out_last) begin
                        state_d     = ACCUM;
                        drain_cnt_d = '0;
                        sat_d       = 1'b0;
                    end else begin
                        drain_cnt_d = drain_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    assign overflow = sat_q;
    assign busy     = (state_q == DRAIN) || (row_cnt_q != '0) || (tile_cnt_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            row_cnt_q   <= '0;
            drain_cnt_q <= '0;
            tile_cnt_q  <= '0;
            sat_q       <= 1'b0;
            for (int r = 0; r < N; r++) begin
                for (int k = 0; k < N; k++) begin
                    acc_q[r][k] <= '0;
                end
            end
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            tile_cnt_q  <= tile_cnt_d;
            sat_q       <= sat_d;
            acc_q       <= acc_d;
        end
    end

endmodule

// File: tb/tb_dip_psum_collector.sv
// Scoreboard bench: two collectors (ACC_W=32 and ACC_W=24) share stimulus; a tile-sum
// reference model fills per-DUT expected-row queues that a negedge monitor drains.
module tb_dip_psum_collector;

    localparam int N      = 4;
    localparam int PSUM_W = 24;
    localparam int NT     = 2;
    localparam int WA     = 32;
    localparam int WB     = 24;

    typedef struct packed {
        logic [N-1:0][63:0] lane;
        logic               ovf;
        logic               last;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 in_valid = 1'b0;
    logic [N*PSUM_W-1:0]  in_row = '0;
    logic                 out_ready = 1'b0;
    logic                 in_ready_a, out_valid_a, out_last_a, overflow_a, busy_a;
    logic                 in_ready_b, out_valid_b, out_last_b, overflow_b, busy_b;
    logic [N*WA-1:0]      out_row_a;
    logic [N*WB-1:0]      out_row_b;

    exp_t                 qa[$];
    exp_t                 qb[$];
    logic [N*PSUM_W-1:0]  pend[$];
    int                   errors = 0;
    int                   checks = 0;
    int                   ready_mode = 0;
    logic                 stall_prev = 1'b0;
    logic [N*WA-1:0]      held_a = '0;

    always #5 clk = ~clk;

    dip_psum_collector #(.N(N), .PSUM_W(PSUM_W), .ACC_W(WA), .NUM_TILES(NT)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_row(in_row),
        .in_ready(in_ready_a), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_row(out_row_a), .out_last(out_last_a), .overflow(overflow_a), .busy(busy_a)
    );

    dip_psum_collector #(.N(N), .PSUM_W(PSUM_W), .ACC_W(WB), .NUM_TILES(NT)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_row(in_row),
        .in_ready(in_ready_b), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_row(out_row_b), .out_last(out_last_b), .overflow(overflow_b), .busy(busy_b)
    );

    function automatic longint sx(input logic [PSUM_W-1:0] v);
        return v[PSUM_W-1] ? longint'(v) - (longint'(1) << PSUM_W) : longint'(v);
    endfunction

    function automatic longint clampw(input longint v, input int w, output bit hit);
        longint lim;
        lim = longint'(1) << (w - 1);
        hit = 1'b0;
        if (v > lim - 1) begin
            hit = 1'b1;
            return lim - 1;
        end
        if (v < -lim) begin
            hit = 1'b1;
            return -lim;
        end
        return v;
    endfunction

    function automatic logic [63:0] ext(input logic [63:0] raw, input int w);
        return raw[w-1] ? (raw | (~64'd0 << w)) : (raw & ~(~64'd0 << w));
    endfunction

    // Result lane (r,k) = running clamped sum over tiles of row r, lane k.
    task automatic build_result(input int w, output exp_t rows [N]);
        bit ovf, hit;
        longint acc;
        logic [N*PSUM_W-1:0] row;
        ovf = 1'b0;
        for (int r = 0; r < N; r++) begin
            for (int k = 0; k < N; k++) begin
                row = pend[r];
                acc = sx(row[k*PSUM_W +: PSUM_W]);
                for (int t = 1; t < NT; t++) begin
                    row = pend[t*N + r];
                    acc = clampw(acc + sx(row[k*PSUM_W +: PSUM_W]), w, hit);
                    ovf |= hit;
                end
                rows[r].lane[k] = 64'(acc);
            end
            rows[r].last = (r == N - 1);
        end
        for (int r = 0; r < N; r++) rows[r].ovf = ovf;
    endtask

    task automatic accept_row(input logic [N*PSUM_W-1:0] row);
        exp_t ra [N];
        exp_t rb [N];
        pend.push_back(row);
        if (pend.size() == N * NT) begin
            build_result(WA, ra);
            build_result(WB, rb);
            for (int r = 0; r < N; r++) begin
                qa.push_back(ra[r]);
                qb.push_back(rb[r]);
            end
            pend.delete();
        end
    endtask

    // Called at a negedge; in_ready is state-only so its negedge value holds at the next posedge.
    task automatic send_row(input logic [N*PSUM_W-1:0] row, input bit bub);
        int guard;
        if (bub) repeat ($urandom_range(0, 3)) @(negedge clk);
        in_valid = 1'b1;
        in_row   = row;
        guard    = 0;
        while (in_ready_a !== 1'b1 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready=%b required=1", in_ready_a);
        end else begin
            accept_row(row);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((qa.size() != 0 || qb.size() != 0) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending_a=%0d pending_b=%0d required=0", qa.size(), qb.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h required=%h", nm, got, exp);
        end
    endtask

    task automatic compare_row(input string nm, input exp_t e, input logic [N-1:0][63:0] got,
                               input logic lst, input logic ovf);
        for (int k = 0; k < N; k++) chk($sformatf("%s_lane%0d", nm, k), got[k], e.lane[k]);
        chk({nm, "_last"}, 64'(lst), 64'(e.last));
        chk({nm, "_overflow"}, 64'(ovf), 64'(e.ovf));
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_out_valid"}, 64'({out_valid_a, out_valid_b}), 64'd0);
        chk({nm, "_in_ready"}, 64'({in_ready_a, in_ready_b}), 64'd3);
        chk({nm, "_busy"}, 64'({busy_a, busy_b}), 64'd0);
        chk({nm, "_last_ovf"}, 64'({out_last_a, out_last_b, overflow_a, overflow_b}), 64'd0);
        chk({nm, "_out_row"}, 64'(|{out_row_a, out_row_b}), 64'd0);
    endtask

    always @(negedge clk) begin
        logic [N-1:0][63:0] ga;
        logic [N-1:0][63:0] gb;
        exp_t e;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (stall_prev) begin
                chk("hold_valid", 64'(out_valid_a), 64'd1);
                chk("hold_row", 64'(out_row_a == held_a), 64'd1);
            end
            if (out_valid_a) chk("drain_in_ready", 64'({in_ready_a, in_ready_b}), 64'd0);
            for (int k = 0; k < N; k++) begin
                ga[k] = ext(64'(out_row_a[k*WA +: WA]), WA);
                gb[k] = ext(64'(out_row_b[k*WB +: WB]), WB);
            end
            if (out_valid_a && out_ready) begin
                if (qa.size() == 0) begin
                    chk("a_unexpected_row", 64'(out_valid_a), 64'd0);
                end else begin
                    e = qa.pop_front();
                    compare_row("a", e, ga, out_last_a, overflow_a);
                end
            end
            if (out_valid_b && out_ready) begin
                if (qb.size() == 0) begin
                    chk("b_unexpected_row", 64'(out_valid_b), 64'd0);
                end else begin
                    e = qb.pop_front();
                    compare_row("b", e, gb, out_last_b, overflow_b);
                end
            end
            stall_prev = out_valid_a && !out_ready;
            held_a     = out_row_a;
        end
    end

    function automatic logic [N*PSUM_W-1:0] fill(input logic [PSUM_W-1:0] v);
        logic [N*PSUM_W-1:0] r;
        for (int k = 0; k < N; k++) r[k*PSUM_W +: PSUM_W] = v;
        return r;
    endfunction

    function automatic logic [PSUM_W-1:0] rand_lane();
        case ($urandom_range(0, 5))
            0:       return 24'h7FFFFF;
            1:       return 24'h800000;
            2:       return PSUM_W'($urandom_range(0, 31));
            default: return PSUM_W'($urandom);
        endcase
    endfunction

    function automatic logic [N*PSUM_W-1:0] rand_row();
        logic [N*PSUM_W-1:0] r;
        for (int k = 0; k < N; k++) r[k*PSUM_W +: PSUM_W] = rand_lane();
        return r;
    endfunction

    initial begin
        logic [N*PSUM_W-1:0] row;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Constant tiles: 5 + (-3) = 2 everywhere.
        ready_mode = 0;
        for (int i = 0; i < N; i++) send_row(fill(24'd5), 1'b0);
        for (int i = 0; i < N; i++) send_row(fill(-24'sd3), 1'b0);
        wait_drain();

        // Index pattern with toggling consumer.
        ready_mode = 1;
        for (int t = 0; t < NT; t++) begin
            for (int r = 0; r < N; r++) begin
                for (int k = 0; k < N; k++) row[k*PSUM_W +: PSUM_W] = PSUM_W'(16*r + k);
                send_row(row, 1'b0);
            end
        end
        wait_drain();

        // Positive extreme on lane 0, then a clean result.
        ready_mode = 0;
        for (int i = 0; i < N*NT; i++) begin
            row = fill(PSUM_W'(i));
            row[PSUM_W-1:0] = 24'h7FFFFF;
            send_row(row, 1'b0);
        end
        wait_drain();
        for (int i = 0; i < N*NT; i++) send_row(fill(PSUM_W'(i + 1)), 1'b0);
        wait_drain();

        // Negative extreme on lane 0.
        for (int i = 0; i < N*NT; i++) begin
            row = fill(-24'sd7);
            row[PSUM_W-1:0] = 24'h800000;
            send_row(row, 1'b0);
        end
        wait_drain();

        // Reset in the middle of accumulation.
        for (int i = 0; i < 6; i++) send_row(rand_row(), 1'b0);
        chk("busy_mid", 64'({busy_a, busy_b}), 64'd3);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        pend.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N*NT; i++) send_row(rand_row(), 1'b0);
        wait_drain();

        // Back-to-back randomized results with bubbles and random backpressure.
        ready_mode = 2;
        for (int res = 0; res < 8; res++) begin
            for (int i = 0; i < N*NT; i++) send_row(rand_row(), 1'b1);
        end
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
